cle_sram_arb: RTL
=================

// Module: cle_sram_arb
// PURPOSE
//  Two-requester arbiter sharing the single-port sram_1024x8 label memory of the CLE.
//  Requester 0 = raster-scan labeler; requester 1 = equivalence-merge/relabel pass.
//  Grants one access per cycle, drives SRAM A/D/WEN and returns read data one cycle later.
//  Round-robin fairness, with bounded lock bursts for read-modify-write sequences.
// PARAMETERS
//  AW        10  SRAM address width (1024 words, addr = row*32+col)
//  DW        8   SRAM data width (label value)
//  MAX_LOCK  8   max consecutive grants to a locked requester before forced release
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  reset      in   1   synchronous, active-high reset
//  req0/req1      in   1   access request, held until granted
//  lock0/lock1    in   1   keep grant on following cycles while req held
//  we0/we1        in   1   1 = write, 0 = read
//  addr0/addr1    in   AW  word address
//  wdata0/wdata1  in   DW  write data
//  gnt0/gnt1      out  1   access accepted this cycle (combinational)
//  rvalid0/rvalid1 out 1   read data valid for that requester
//  rdata      out  DW  read data (= sram_q), qualified by rvalid0/1
//  sram_q     in   DW  SRAM output, valid the cycle after a read address
//  sram_a     out  AW  SRAM address
//  sram_d     out  DW  SRAM write data
//  sram_wen   out  1   SRAM write enable, active-low
//  busy       out  1   any grant or read return in flight
// BEHAVIOUR
//  Reset (sync, checked first): gnt*=0, rvalid*=0, sram_wen=1, sram_a=0, sram_d=0,
//   rr_ptr=0 (req0 preferred), lock_owner=none, lock_cnt=0, busy=0. A pending read is dropped.
//  Arbitration in cycle t (combinational on registered state):
//   - lock_owner=k and req_k=1 and lock_cnt<MAX_LOCK: grant k.
//   - else: only one requester active -> grant it; both active -> grant rr_ptr.
//   - no req -> no grant, sram_wen=1, sram_a/sram_d hold last granted values (registered copy).
//  On grant k: sram_a=addr_k, sram_d=wdata_k, sram_wen=~we_k in the same cycle; gnt_k=1.
//  Read latency 1: read granted in t -> rvalid_k=1 in t+1 with rdata=sram_q.
//   Writes never produce rvalid. Back-to-back reads stream: one rvalid per cycle.
//  Read-after-write to the same address in t+1 returns the new data (SRAM property; no bypass).
//  rr_ptr update on grant of k without lock continuation: rr_ptr <= ~k.
//  Lock: grant with lock_k=1 sets lock_owner=k, lock_cnt++. lock_owner clears when req_k or
//   lock_k drops, or when lock_cnt reaches MAX_LOCK. Forced release sets rr_ptr=~k; the other
//   requester (if requesting) wins next cycle. lock_cnt resets to 0 on release.
//  Simultaneous lock0 and lock1 with no owner: the rr winner becomes owner.
//  Requester inputs are sampled only in the granted cycle; changes while not granted are ignored.
//  busy = gnt0|gnt1|rvalid0|rvalid1.
//  Starvation bound: a continuously requesting port waits at most MAX_LOCK+1 cycles.
// STRUCTURE
//  Shared package cle_pkg: IMG_W=32, IMG_H=32, SRAM_AW=10, SRAM_DW=8, LABEL_BG=8'h00.
//  Single module. No natural sub-module; the read-return tag (1-bit owner + valid) is an
//   inline register, not a FIFO.
// TESTING
//  1 Reset mid-read: read granted, reset asserted the next cycle -> rvalid0=0, sram_wen=1, rr_ptr=0.
//  2 Only req0, we0=1, addr0=10'h021, wdata0=8'h05 -> gnt0=1 same cycle, sram_wen=0,
//    mem[33]=05; read back -> rvalid0=1 next cycle, rdata=8'h05.
//  3 req0,req1 held, no lock, after reset -> grants alternate 0,1,0,1; each port at 50%.
//  4 lock1=1 held with req1, req0 held, MAX_LOCK=8 -> 8 consecutive gnt1, then gnt0 once,
//    then gnt1 again.
//  5 Back-to-back reads: port 1 at addr 0..3 preloaded 8'h0A..8'h0D -> rvalid1 on 4 consecutive
//    cycles with rdata 0A,0B,0C,0D.
//  6 Idle after write to addr 10'h3FF -> sram_a holds 3FF, sram_wen=1, busy=0, memory unchanged.

Source files
------------

// File: rtl/cle_pkg.sv
// Shared constants for the connected-label-extraction (CLE) block: image geometry,
// label SRAM shape and the background label value.
package cle_pkg;
   localparam int IMG_W          = 32;
   localparam int IMG_H          = 32;
   localparam int SRAM_AW        = 10;
   localparam int SRAM_DW        = 8;
   localparam logic [7:0] LABEL_BG = 8'h00;
   localparam int ARB_MAX_LOCK   = 8;

   // Port identifiers of the label-SRAM arbiter.
   typedef enum logic {
      PORT_RASTER = 1'b0,
      PORT_MERGE  = 1'b1
   } arb_port_e;
endpackage

// File: rtl/cle_sram_arb.sv
// Two-requester round-robin arbiter in front of the single-port label SRAM, with
// bounded lock bursts for read-modify-write sequences and a one-cycle read return.
module cle_sram_arb
   import cle_pkg::*;
#(
   parameter int AW       = SRAM_AW,
   parameter int DW       = SRAM_DW,
   parameter int MAX_LOCK = ARB_MAX_LOCK
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req0,
   input  logic          req1,
   input  logic          lock0,
   input  logic          lock1,
   input  logic          we0,
   input  logic          we1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic          gnt0,
   output logic          gnt1,
   output logic          rvalid0,
   output logic          rvalid1,
   output logic [DW-1:0] rdata,
   input  logic [DW-1:0] sram_q,
   output logic [AW-1:0] sram_a,
   output logic [DW-1:0] sram_d,
   output logic          sram_wen,
   output logic          busy
);
   localparam int CW = $clog2(MAX_LOCK + 1);

   logic          rr_ptr_reg;
   logic          lock_vld_reg;
   arb_port_e     lock_id_reg;
   logic [CW-1:0] lock_cnt_reg;
   logic          rd_vld_reg;
   arb_port_e     rd_tag_reg;
   logic [AW-1:0] sram_a_reg;
   logic [DW-1:0] sram_d_reg;

   logic          lock_hit;
   logic          gnt_any;
   arb_port_e     gnt_id;
   logic          g_we;
   logic          g_lock;
   logic [AW-1:0] g_addr;
   logic [DW-1:0] g_wdata;
   logic [CW-1:0] cnt_inc;

   // A live lock owner keeps the SRAM until it lets go or exhausts its burst.
   assign lock_hit = lock_vld_reg
                   && ((lock_id_reg == PORT_MERGE) ? req1 : req0)
                   && (lock_cnt_reg < CW'(MAX_LOCK));

   always_comb begin
      gnt_any = 1'b0;
      gnt_id  = PORT_RASTER;
      if (lock_hit) begin
         gnt_any = 1'b1;
         gnt_id  = lock_id_reg;
      end else if (req0 && req1) begin
         gnt_any = 1'b1;
         gnt_id  = arb_port_e'(rr_ptr_reg);
      end else if (req0) begin
         gnt_any = 1'b1;
         gnt_id  = PORT_RASTER;
      end else if (req1) begin
         gnt_any = 1'b1;
         gnt_id  = PORT_MERGE;
      end
   end

   assign g_we    = (gnt_id == PORT_MERGE) ? we1    : we0;
   assign g_lock  = (gnt_id == PORT_MERGE) ? lock1  : lock0;
   assign g_addr  = (gnt_id == PORT_MERGE) ? addr1  : addr0;
   assign g_wdata = (gnt_id == PORT_MERGE) ? wdata1 : wdata0;

   // Burst length continues only when the same port already owns the lock.
   assign cnt_inc = ((lock_vld_reg && (lock_id_reg == gnt_id)) ? lock_cnt_reg : '0) + CW'(1);

   assign gnt0     = gnt_any && (gnt_id == PORT_RASTER);
   assign gnt1     = gnt_any && (gnt_id == PORT_MERGE);
   assign sram_a   = gnt_any ? g_addr  : sram_a_reg;
   assign sram_d   = gnt_any ? g_wdata : sram_d_reg;
   assign sram_wen = ~(gnt_any && g_we);

   assign rvalid0 = rd_vld_reg && (rd_tag_reg == PORT_RASTER);
   assign rvalid1 = rd_vld_reg && (rd_tag_reg == PORT_MERGE);
   assign rdata   = sram_q;
   assign busy    = gnt0 | gnt1 | rvalid0 | rvalid1;

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_reg   <= 1'b0;
         lock_vld_reg <= 1'b0;
         lock_id_reg  <= PORT_RASTER;
         lock_cnt_reg <= '0;
         rd_vld_reg   <= 1'b0;
         rd_tag_reg   <= PORT_RASTER;
         sram_a_reg   <= '0;
         sram_d_reg   <= '0;
      end else begin
         rd_vld_reg <= gnt_any && !g_we;
         rd_tag_reg <= gnt_id;
         if (gnt_any) begin
            sram_a_reg <= g_addr;
            sram_d_reg <= g_wdata;
            rr_ptr_reg <= ~gnt_id;
            // Reaching MAX_LOCK is a forced release; rr_ptr already favours the other port.
            if (g_lock && (cnt_inc < CW'(MAX_LOCK))) begin
               lock_vld_reg <= 1'b1;
               lock_id_reg  <= gnt_id;
               lock_cnt_reg <= cnt_inc;
            end else begin
               lock_vld_reg <= 1'b0;
               lock_cnt_reg <= '0;
            end
         end else begin
            lock_vld_reg <= 1'b0;
            lock_cnt_reg <= '0;
         end
      end
   end
endmodule
